// File: rtl/crc_engine.sv
// rtl/crc_engine.sv - parametrised bit-serial CRC generator/checker with start/done handshake
module crc_engine #(
    parameter int               DATA_W = 32,
    parameter int               CRC_W  = 16,
    parameter logic [CRC_W-1:0] POLY   = 16'h1021,
    parameter logic [CRC_W-1:0] INIT   = 16'hFFFF,
    parameter bit               REFIN  = 1'b0,
    parameter bit               REFOUT = 1'b0,
    parameter logic [CRC_W-1:0] XOROUT = 16'h0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              first_i,
    input  logic [DATA_W-1:0] data_in_i,
    input  logic [CRC_W-1:0]  ref_crc_i,
    output logic              ready_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [CRC_W-1:0]  crc_out_o,
    output logic              match_o
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_FINISH
    } state_e;

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [CRC_W-1:0]   raw_q, raw_d;
    logic [CRC_W-1:0]   ref_q, ref_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CRC_W-1:0]   crc_out_q, crc_out_d;
    logic               match_q, match_d;

    logic               bit_in;
    logic               fb;
    logic [CRC_W-1:0]   raw_shifted;
    logic [CRC_W-1:0]   raw_final;

    function automatic logic [CRC_W-1:0] reverse_crc(input logic [CRC_W-1:0] v);
        logic [CRC_W-1:0] r;
        r = '0;
        for (int i = 0; i < CRC_W; i++) begin
            r[i] = v[CRC_W-1-i];
        end
        return r;
    endfunction

    // Datapath helpers: next message bit, one LFSR step, and the finalised result
    always_comb begin
        bit_in      = REFIN ? data_q[0] : data_q[DATA_W-1];
        fb          = raw_q[CRC_W-1] ^ bit_in;
        raw_shifted = {raw_q[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
        raw_final   = (REFOUT ? reverse_crc(raw_q) : raw_q) ^ XOROUT;
    end

    // Next-state logic; the raw register is never finalised so it can chain words
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        raw_d     = raw_q;
        ref_d     = ref_q;
        cnt_d     = cnt_q;
        crc_out_d = crc_out_q;
        match_d   = match_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    data_d  = data_in_i;
                    ref_d   = ref_crc_i;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                    if (first_i) begin
                        raw_d = INIT;
                    end
                end
            end
            S_SHIFT: begin
                if (cnt_q == CNT_W'(DATA_W)) begin
                    // All bits consumed: publish result so it is valid while done is high
                    crc_out_d = raw_final;
                    match_d   = (raw_final == ref_q);
                    state_d   = S_FINISH;
                end else begin
                    raw_d  = raw_shifted;
                    data_d = REFIN ? (data_q >> 1) : (data_q << 1);
                    cnt_d  = cnt_q + CNT_W'(1);
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            data_q    <= '0;
            raw_q     <= INIT;
            ref_q     <= '0;
            cnt_q     <= '0;
            crc_out_q <= '0;
            match_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            raw_q     <= raw_d;
            ref_q     <= ref_d;
            cnt_q     <= cnt_d;
            crc_out_q <= crc_out_d;
            match_q   <= match_d;
        end
    end

    assign ready_o   = (state_q == S_IDLE);
    assign busy_o    = (state_q != S_IDLE);
    assign done_o    = (state_q == S_FINISH);
    assign crc_out_o = crc_out_q;
    assign match_o   = match_q;

endmodule
